// File: rtl/gray_code_pipe.sv
// gray_code_pipe: streaming Gray<->binary converter; each word carries its own direction.
// Latency PIPE_STAGES cycles, one word/cycle; elastic valid/ready slices compact on backpressure.
// Optional GRAY_STEP_CHECK_EN adds sticky step_err for Gray-mode inputs that move by 2+ bits.
`timescale 1ns/1ps

module gray_code_pipe #(
  parameter int WIDTH       = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  localparam int LAST = PIPE_STAGES - 1;

  // Prefix XOR from the MSB: each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0]       conv_dat;
  logic [PIPE_STAGES-1:0] stg_vld;
  logic [PIPE_STAGES-1:0] stg_mode;
  logic [WIDTH-1:0]       stg_dat [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stg_load;

  // Whole conversion happens ahead of the first slice; later slices only carry the result.
  always_comb begin
    conv_dat = in_mode ? bin_to_gray(in_data) : gray_to_bin(in_data);
  end

  // A slice may load when it, or any slice downstream of it, has a hole, or the output drains.
  // Written as an OR over downstream valids so there is no combinational self-reference.
  always_comb begin
    stg_load = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      stg_load[k] = out_ready;
      for (int j = 0; j < PIPE_STAGES; j++) begin
        if (j >= k && !stg_vld[j]) begin
          stg_load[k] = 1'b1;
        end
      end
    end
  end

  assign in_ready = stg_load[0];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic             vld;
    logic             mode;
    logic [WIDTH-1:0] dat;
    logic             src_vld;
    logic             src_mode;
    logic [WIDTH-1:0] src_dat;

    if (k == 0) begin : g_src
      assign src_vld  = in_valid;
      assign src_mode = in_mode;
      assign src_dat  = conv_dat;
    end else begin : g_src
      assign src_vld  = stg_vld[k-1];
      assign src_mode = stg_mode[k-1];
      assign src_dat  = stg_dat[k-1];
    end

    // Slice register: payload only captured with a valid word so a held output never changes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld  <= 1'b0;
        mode <= 1'b0;
        dat  <= '0;
      end else if (stg_load[k]) begin
        vld <= src_vld;
        if (src_vld) begin
          mode <= src_mode;
          dat  <= src_dat;
        end
      end
    end

    assign stg_vld[k]  = vld;
    assign stg_mode[k] = mode;
    assign stg_dat[k]  = dat;
  end

  assign out_valid = stg_vld[LAST];
  assign out_mode  = stg_mode[LAST];
  assign out_data  = stg_dat[LAST];

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] ref_gray;
  logic             ref_vld;
  logic [WIDTH-1:0] step_diff;
  logic             multi_bit;

  // Two or more differing bits leave a nonzero value after clearing the lowest set bit.
  assign step_diff = in_data ^ ref_gray;
  assign multi_bit = |(step_diff & (step_diff - WIDTH'(1)));

  // Track the last accepted Gray-mode word; binary-mode words are ignored entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_gray <= '0;
      ref_vld  <= 1'b0;
      step_err <= 1'b0;
    end else if (in_valid && in_ready && !in_mode) begin
      ref_gray <= in_data;
      ref_vld  <= 1'b1;
      if (ref_vld && multi_bit) begin
        step_err <= 1'b1;
      end
    end
  end
`endif

endmodule
